// File: rtl/clk_phase_decoder_4004.sv
// Receive end of the 4004 two-phase clock: phase strobes, machine-cycle index and lock/health flags.
// Optional CLKDEC_SYNC2_EN adds a 2-flop synchroniser on clk1/clk2/sync for an asynchronous bus.
module clk_phase_decoder_4004 #(
  parameter int QC         = 10,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       eclk,
  input  logic       ereset_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  output logic       ph1_stb,
  output logic       ph2_stb,
  output logic       mcyc_stb,
  output logic [2:0] subcycle,
  output logic       sub_valid,
  output logic       locked,
  output logic       err_period,
  output logic       err_sync,
  output logic       err_overlap,
  output logic       err_timeout
);
  localparam int PCW = $clog2(TIMEOUT + 1);
  localparam int MW  = PCW + 1;
  localparam int GW  = $clog2(LOCK_COUNT + 1);
  localparam logic [PCW-1:0] PC_MAX  = PCW'(TIMEOUT);
  localparam logic [PCW-1:0] PC_LAST = PCW'(TIMEOUT - 1);
  localparam logic [MW-1:0]  P_MIN   = MW'(4 * QC - TOL);
  localparam logic [MW-1:0]  P_MAX   = MW'(4 * QC + TOL);
  localparam logic [GW-1:0]  GOOD_LK = GW'(LOCK_COUNT);

  logic c1_in, c2_in, sy_in;

`ifdef CLKDEC_SYNC2_EN
  logic [1:0] c1_meta, c2_meta, sy_meta;

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      c1_meta <= '0;
      c2_meta <= '0;
      sy_meta <= '0;
    end else begin
      c1_meta <= {c1_meta[0], clk1};
      c2_meta <= {c2_meta[0], clk2};
      sy_meta <= {sy_meta[0], sync};
    end
  end

  assign c1_in = c1_meta[1];
  assign c2_in = c2_meta[1];
  assign sy_in = sy_meta[1];
`else
  assign c1_in = clk1;
  assign c2_in = clk2;
  assign sy_in = sync;
`endif

  logic           s1, s2, ss, s1_prev, s2_prev;
  logic           rise1, rise2;
  logic [PCW-1:0] pc;
  logic [MW-1:0]  meas;
  logic           armed, in_range, timeout_hit, sync_pend;
  logic [GW-1:0]  good, good_inc;

  assign rise1    = s1 & ~s1_prev;
  assign rise2    = s2 & ~s2_prev;
  assign meas     = {1'b0, pc} + MW'(1);
  assign in_range = (meas >= P_MIN) && (meas <= P_MAX);
  assign good_inc = (good == GOOD_LK) ? good : good + GW'(1);
  // The watchdog only runs once a rise has armed it; a rise on the last count wins.
  assign timeout_hit = armed & ~rise1 & (pc == PC_LAST);

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      ss          <= 1'b0;
      s1_prev     <= 1'b0;
      s2_prev     <= 1'b0;
      pc          <= '0;
      armed       <= 1'b0;
      good        <= '0;
      sync_pend   <= 1'b0;
      ph1_stb     <= 1'b0;
      ph2_stb     <= 1'b0;
      mcyc_stb    <= 1'b0;
      subcycle    <= 3'd0;
      sub_valid   <= 1'b0;
      locked      <= 1'b0;
      err_period  <= 1'b0;
      err_sync    <= 1'b0;
      err_overlap <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      s1         <= c1_in;
      s2         <= c2_in;
      ss         <= sy_in;
      s1_prev    <= s1;
      s2_prev    <= s2;
      ph1_stb    <= rise1;
      ph2_stb    <= rise2;
      mcyc_stb   <= 1'b0;
      err_period <= 1'b0;
      err_sync   <= 1'b0;

      if (rise1) begin
        pc    <= '0;
        armed <= 1'b1;
        if (armed) begin
          if (in_range) begin
            good <= good_inc;
            if (good_inc == GOOD_LK) locked <= 1'b1;
          end else begin
            good       <= '0;
            locked     <= 1'b0;
            err_period <= 1'b1;
          end
        end
      end else if (pc != PC_MAX) begin
        pc <= pc + PCW'(1);
      end

      if (timeout_hit) begin
        err_timeout <= 1'b1;
        locked      <= 1'b0;
        good        <= '0;
        armed       <= 1'b0;
        sub_valid   <= 1'b0;
      end

      // Overlap overrides any lock progress made by a coincident rise.
      if (s1 & s2) begin
        err_overlap <= 1'b1;
        locked      <= 1'b0;
        good        <= '0;
      end

      if (rise1) begin
        if (sync_pend) begin
          subcycle  <= 3'd0;
          mcyc_stb  <= 1'b1;
          sub_valid <= 1'b1;
          // Before the first SYNC the index is meaningless, so no misalignment is reported.
          err_sync  <= sub_valid & (subcycle != 3'd7);
        end else begin
          subcycle <= subcycle + 3'd1;
          mcyc_stb <= sub_valid & (subcycle == 3'd7);
        end
        sync_pend <= rise2 & ss;
      end else if (rise2 & ss) begin
        sync_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clk_phase_decoder_4004.sv
// Bench for clk_phase_decoder_4004: directed scenarios plus random clock trains, checked every
// cycle against an event-level model built from input history and rise-to-rise times.
module tb_clk_phase_decoder_4004;
  localparam int QC = 10, TOL = 2, LC = 4, TIMEOUT = 64;
`ifdef CLKDEC_SYNC2_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic eclk = 1'b0, ereset_n = 1'b0, clk1 = 1'b0, clk2 = 1'b0, sync = 1'b0;
  logic ph1_stb, ph2_stb, mcyc_stb, sub_valid, locked;
  logic err_period, err_sync, err_overlap, err_timeout;
  logic [2:0] subcycle;

  clk_phase_decoder_4004 #(.QC(QC), .TOL(TOL), .LOCK_COUNT(LC), .TIMEOUT(TIMEOUT)) dut (
    .eclk(eclk), .ereset_n(ereset_n), .clk1(clk1), .clk2(clk2), .sync(sync),
    .ph1_stb(ph1_stb), .ph2_stb(ph2_stb), .mcyc_stb(mcyc_stb), .subcycle(subcycle),
    .sub_valid(sub_valid), .locked(locked), .err_period(err_period), .err_sync(err_sync),
    .err_overlap(err_overlap), .err_timeout(err_timeout)
  );

  // clock / reset
  always #5 eclk = ~eclk;

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [11:0] dut_word, exp_word;
  assign dut_word = {ph1_stb, ph2_stb, mcyc_stb, subcycle, sub_valid, locked,
                     err_period, err_sync, err_overlap, err_timeout};

  // reference model: per-edge input history, rise times and spec rules
  bit h1[0:5], h2[0:5], hs[0:5];
  int cyc = 0, last_rise = 0, good = 0, m_sub = 0;
  bit armed, m_locked, m_sv, m_pend, m_eo, m_et;
  bit p_ph1, p_ph2, p_mc, p_ep, p_es, r1, r2;
  int per;

  always @(posedge eclk) begin
    cyc++;
    if (!ereset_n) begin
      for (int i = 0; i < 6; i++) begin h1[i] = 0; h2[i] = 0; hs[i] = 0; end
      good = 0; m_sub = 0; armed = 0; m_locked = 0; m_sv = 0; m_pend = 0; m_eo = 0; m_et = 0;
      p_ph1 = 0; p_ph2 = 0; p_mc = 0; p_ep = 0; p_es = 0;
    end else begin
      for (int i = 5; i > 0; i--) begin h1[i] = h1[i-1]; h2[i] = h2[i-1]; hs[i] = hs[i-1]; end
      h1[0] = clk1; h2[0] = clk2; hs[0] = sync;
      r1 = h1[1+D] && !h1[2+D];
      r2 = h2[1+D] && !h2[2+D];
      p_ph1 = r1; p_ph2 = r2; p_mc = 0; p_ep = 0; p_es = 0;
      if (r1) begin
        if (armed) begin
          per = cyc - last_rise;
          if (per >= 4*QC-TOL && per <= 4*QC+TOL) begin
            good = (good < LC) ? good + 1 : LC;
            if (good == LC) m_locked = 1;
          end else begin
            good = 0; m_locked = 0; p_ep = 1;
          end
        end
        armed = 1; last_rise = cyc;
      end else if (armed && cyc - last_rise == TIMEOUT) begin
        m_et = 1; m_locked = 0; good = 0; armed = 0; m_sv = 0;
      end
      if (h1[1+D] && h2[1+D]) begin m_eo = 1; m_locked = 0; good = 0; end
      if (r1) begin
        if (m_pend) begin
          p_es = m_sv && (m_sub != 7);
          m_sub = 0; p_mc = 1; m_sv = 1; m_pend = 0;
        end else begin
          p_mc = m_sv && (m_sub == 7);
          m_sub = (m_sub + 1) % 8;
        end
      end
      if (r2 && hs[1+D]) m_pend = 1;
    end
    exp_word = {p_ph1, p_ph2, p_mc, 3'(m_sub), m_sv, m_locked, p_ep, p_es, m_eo, m_et};
  end

  // scoreboard compare on the opposite edge
  always @(negedge eclk) check("outs", dut_word, ereset_n ? exp_word : 12'h000);

  // drivers
  int pidx = 0, shift = 2;

  task automatic drive(input bit a, input bit b, input bit s);
    clk1 = a; clk2 = b; sync = s;
    @(posedge eclk); #1;
  endtask

  task automatic run_period(input int p, input int hi1, input int off2, input int hi2, input bit sy);
    for (int i = 0; i < p; i++) drive(i < hi1, (i >= off2) && (i < off2 + hi2), sy);
    pidx++;
  endtask

  task automatic nominal(input int p);
    run_period(p, 10, 20, 10, ((pidx + shift) % 8) == 7);
  endtask

  task automatic reset_pulse();
    ereset_n = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    ereset_n = 1'b1;
  endtask

  initial begin
    @(posedge eclk); #1;
    // 1: reset holds everything at zero
    for (int i = 0; i < 20; i++) drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    check("rst_outs", dut_word, 12'h000);
    ereset_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(0, 0, 0);
    check("idle_outs", dut_word, 12'h000);
    // 2: nominal clocks with SYNC every 8th subcycle
    for (int j = 0; j < 24; j++) nominal(40);
    check("locked_nom", {11'b0, locked}, 12'h001);
    check("sub_valid_nom", {11'b0, sub_valid}, 12'h001);
    // 3: SYNC moved to a different subcycle, then held there
    shift = 5;
    for (int j = 0; j < 16; j++) nominal(40);
    check("sub_valid_resync", {11'b0, sub_valid}, 12'h001);
    // tolerance edges keep lock
    nominal(42); nominal(38); nominal(42); nominal(38); nominal(40);
    check("locked_tol_edge", {11'b0, locked}, 12'h001);
    // 4: one long period drops lock; four good periods regain it
    nominal(45);
    for (int j = 0; j < 4; j++) nominal(40);
    check("locked_after_4", {11'b0, locked}, 12'h000);
    nominal(40);
    check("locked_relock", {11'b0, locked}, 12'h001);
    // a 64-cycle period: the rise wins over the timeout
    nominal(64); nominal(40);
    check("tout_edge64", {11'b0, err_timeout}, 12'h000);
    // 5: clk1 stalls
    for (int i = 0; i < 100; i++) drive(0, 0, 0);
    check("tout_set", {9'b0, err_timeout, locked, sub_valid}, 12'h004);
    for (int j = 0; j < 6; j++) nominal(40);
    check("tout_sticky", {11'b0, err_timeout}, 12'h001);
    check("locked_after_to", {11'b0, locked}, 12'h001);
    // 6: overlapping phases for 3 cycles
    run_period(40, 10, 7, 10, 0);
    check("overlap_set", {10'b0, err_overlap, locked}, 12'h002);
    for (int j = 0; j < 2; j++) nominal(40);
    check("overlap_sticky", {11'b0, err_overlap}, 12'h001);
    reset_pulse();
    check("overlap_clr", dut_word, 12'h000);
    // random clock trains
    for (int j = 0; j < 80; j++) begin
      int p, hi1, off2;
      bit sy;
      p = ($urandom_range(0, 5) == 0) ? $urandom_range(34, 48) : 40;
      hi1 = p / 4;
      off2 = ($urandom_range(0, 15) == 0) ? hi1 - 2 : p / 2;
      sy = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : (((pidx + shift) % 8) == 7);
      run_period(p, hi1, off2, p / 4, sy);
      if ($urandom_range(0, 19) == 0) for (int i = 0; i < 70; i++) drive(0, 0, 0);
      if ($urandom_range(0, 29) == 0) reset_pulse();
    end
    for (int i = 0; i < 10; i++) drive(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
